// File: rtl/decryption_regfile_arbiter_if.sv
// rtl/decryption_regfile_arbiter_if.sv - requester, register-file and status bus of the regfile arbiter
interface decryption_regfile_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH  = 16
);
    // requester port 0
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic                  m0_read;
    logic                  m0_write;
    logic [REG_WIDTH-1:0]  m0_wdata;
    logic [REG_WIDTH-1:0]  m0_rdata;
    logic                  m0_done;
    logic                  m0_error;

    // requester port 1
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic                  m1_read;
    logic                  m1_write;
    logic [REG_WIDTH-1:0]  m1_wdata;
    logic [REG_WIDTH-1:0]  m1_rdata;
    logic                  m1_done;
    logic                  m1_error;

    // shared register-file access bus
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic                  rf_read;
    logic                  rf_write;
    logic [REG_WIDTH-1:0]  rf_wdata;
    logic [REG_WIDTH-1:0]  rf_rdata;
    logic                  rf_done;
    logic                  rf_error;

    // status
    logic                  busy;
    logic                  grant;

    // arbiter side
    modport slave (
        input  m0_addr, m0_read, m0_write, m0_wdata,
        output m0_rdata, m0_done, m0_error,
        input  m1_addr, m1_read, m1_write, m1_wdata,
        output m1_rdata, m1_done, m1_error,
        output rf_addr, rf_read, rf_write, rf_wdata,
        input  rf_rdata, rf_done, rf_error,
        output busy, grant
    );

    // requesters plus register file side
    modport master (
        output m0_addr, m0_read, m0_write, m0_wdata,
        input  m0_rdata, m0_done, m0_error,
        output m1_addr, m1_read, m1_write, m1_wdata,
        input  m1_rdata, m1_done, m1_error,
        input  rf_addr, rf_read, rf_write, rf_wdata,
        output rf_rdata, rf_done, rf_error,
        input  busy, grant
    );
endinterface

// File: rtl/decryption_regfile_arbiter.sv
// rtl/decryption_regfile_arbiter.sv - two-port round-robin arbiter for the decryption_regfile access bus (optional ARB_TIMEOUT_EN)
module decryption_regfile_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int REG_WIDTH  = 16,
    parameter int TIMEOUT    = 16
) (
    input logic                         clk,
    input logic                         rst,
    decryption_regfile_arbiter_if.slave bus
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("decryption_regfile_arbiter: TIMEOUT must be within 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q;
    logic                  last_grant_q;
    logic                  grant_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [REG_WIDTH-1:0]  wdata_q;
    logic                  op_write_q;
    logic                  op_illegal_q;

    logic [ADDR_WIDTH-1:0] rf_addr_q;
    logic [REG_WIDTH-1:0]  rf_wdata_q;
    logic                  rf_read_q;
    logic                  rf_write_q;

    logic [REG_WIDTH-1:0]  m0_rdata_q;
    logic                  m0_done_q;
    logic                  m0_error_q;
    logic [REG_WIDTH-1:0]  m1_rdata_q;
    logic                  m1_done_q;
    logic                  m1_error_q;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]            wait_cnt_q;
`endif

    logic                  m0_pend_d;
    logic                  m1_pend_d;
    logic                  grant_d;
    logic                  pick_read_d;
    logic                  pick_write_d;
    logic [ADDR_WIDTH-1:0] pick_addr_d;
    logic [REG_WIDTH-1:0]  pick_wdata_d;

    logic                  resp_fire_d;
    logic [REG_WIDTH-1:0]  resp_rdata_d;
    logic                  resp_error_d;

    // Round-robin pick: a lone requester wins, a tie goes to the port that did not win last time.
    always_comb begin
        m0_pend_d = bus.m0_read | bus.m0_write;
        m1_pend_d = bus.m1_read | bus.m1_write;
        grant_d   = last_grant_q;
        if (m0_pend_d && m1_pend_d) begin
            grant_d = ~last_grant_q;
        end else if (m0_pend_d) begin
            grant_d = 1'b0;
        end else if (m1_pend_d) begin
            grant_d = 1'b1;
        end
        pick_read_d  = grant_d ? bus.m1_read  : bus.m0_read;
        pick_write_d = grant_d ? bus.m1_write : bus.m0_write;
        pick_addr_d  = grant_d ? bus.m1_addr  : bus.m0_addr;
        pick_wdata_d = grant_d ? bus.m1_wdata : bus.m0_wdata;
    end

    // Decide whether the current cycle completes the transaction, and with what result.
    always_comb begin
        resp_fire_d  = 1'b0;
        resp_rdata_d = '0;
        resp_error_d = 1'b0;
        case (state_q)
            S_ISSUE: begin
                // An illegal read+write request never touches the register file.
                if (op_illegal_q) begin
                    resp_fire_d  = 1'b1;
                    resp_error_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.rf_done) begin
                    resp_fire_d  = 1'b1;
                    resp_rdata_d = op_write_q ? '0 : bus.rf_rdata;
                    resp_error_d = bus.rf_error;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    resp_fire_d  = 1'b1;
                    resp_error_d = 1'b1;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    // Arbiter FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_write_q   <= 1'b0;
            op_illegal_q <= 1'b0;
            rf_addr_q    <= '0;
            rf_wdata_q   <= '0;
            rf_read_q    <= 1'b0;
            rf_write_q   <= 1'b0;
            m0_rdata_q   <= '0;
            m0_done_q    <= 1'b0;
            m0_error_q   <= 1'b0;
            m1_rdata_q   <= '0;
            m1_done_q    <= 1'b0;
            m1_error_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            // Bus drive and port responses last exactly one cycle unless re-armed below.
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            rf_read_q  <= 1'b0;
            rf_write_q <= 1'b0;
            m0_done_q  <= resp_fire_d & ~grant_q;
            m0_rdata_q <= (resp_fire_d & ~grant_q) ? resp_rdata_d : '0;
            m0_error_q <= resp_fire_d & ~grant_q & resp_error_d;
            m1_done_q  <= resp_fire_d & grant_q;
            m1_rdata_q <= (resp_fire_d & grant_q) ? resp_rdata_d : '0;
            m1_error_q <= resp_fire_d & grant_q & resp_error_d;

            case (state_q)
                S_IDLE: begin
                    if (m0_pend_d || m1_pend_d) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        addr_q       <= pick_addr_d;
                        wdata_q      <= pick_wdata_d;
                        op_write_q   <= pick_write_d;
                        op_illegal_q <= pick_read_d & pick_write_d;
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                        if (!(pick_read_d && pick_write_d)) begin
                            rf_addr_q  <= pick_addr_d;
                            rf_wdata_q <= pick_wdata_d;
                            rf_read_q  <= pick_read_d;
                            rf_write_q <= pick_write_d;
                        end
                    end
                end
                S_ISSUE: begin
                    // An illegal request spends its ISSUE cycle idle, then responds.
                    if (op_illegal_q) begin
                        state_q <= S_RESP;
                    end else begin
                        state_q <= S_WAIT;
                    end
`ifdef ARB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                S_WAIT: begin
                    if (resp_fire_d) begin
                        state_q <= S_RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
`endif
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.rf_read  = rf_read_q;
    assign bus.rf_write = rf_write_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m0_done  = m0_done_q;
    assign bus.m0_error = m0_error_q;
    assign bus.m1_rdata = m1_rdata_q;
    assign bus.m1_done  = m1_done_q;
    assign bus.m1_error = m1_error_q;
    assign bus.busy     = busy_q;
    assign bus.grant    = grant_q;

endmodule

// File: doc/decryption_regfile_arbiter.md
# decryption_regfile_arbiter

Two-port round-robin arbiter that shares the single read/write access bus of `decryption_regfile` between two independent requesters, e.g. a host configuration port and an on-chip key loader. Each requester issues one register access at a time; the arbiter serializes them, sends a one-cycle read or write pulse to the register file and waits for its `done`. It then returns `rdata`/`error` to the owning requester with a one-cycle `done` pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: register address width.
- `REG_WIDTH`, 16: register data width.
- `TIMEOUT`, 16: cycles waited for `rf_done` before forcing an error. Used only with `ARB_TIMEOUT_EN`. Legal range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `m0_addr` / `m1_addr`  in  ADDR_WIDTH  requester address, held while the request is pending.
- `m0_read` / `m1_read`  in  1  read request level, held until the port's `done`.
- `m0_write` / `m1_write`  in  1  write request level, held until the port's `done`.
- `m0_wdata` / `m1_wdata`  in  REG_WIDTH  write data, held with `write`.
- `m0_rdata` / `m1_rdata`  out  REG_WIDTH  read data, valid only while the port's `done`=1, otherwise 0.
- `m0_done` / `m1_done`  out  1  one-cycle completion pulse.
- `m0_error` / `m1_error`  out  1  error flag, valid with `done`, otherwise 0.
- `rf_addr`  out  ADDR_WIDTH  to `decryption_regfile.addr`.
- `rf_read`  out  1  one-cycle read pulse.
- `rf_write`  out  1  one-cycle write pulse.
- `rf_wdata`  out  REG_WIDTH  write data.
- `rf_rdata`  in  REG_WIDTH  from the register file.
- `rf_done`  in  1  completion from the register file.
- `rf_error`  in  1  error from the register file.
- `busy`  out  1  high in every state except IDLE.
- `grant`  out  1  index of the current or last owner.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- **IDLE**
  - A port is pending when its `read` or `write` is high.
  - If exactly one port is pending, grant it.
  - If both ports are pending, grant the port not equal to `last_grant`.
  - On a grant: latch that port's addr, wdata and op, update `grant`/`last_grant`, and go to ISSUE.
- **Illegal request**: if the granted port has `read` and `write` both high, skip the register file. Go directly to RESP with `error`=1 and `rdata`=0.
- **ISSUE**
  - Drive `rf_addr`/`rf_wdata` with the latched values.
  - Assert exactly one of `rf_read`/`rf_write` for this single cycle.
  - Go to WAIT.
- **WAIT**
  - `rf_addr` and `rf_wdata` return to 0; `rf_read`/`rf_write` are 0.
  - When `rf_done` is sampled high, capture `rf_rdata` (zeroed for writes) and `rf_error`, then go to RESP.
- **RESP**
  - Assert the granted port's `done` with the captured `rdata`/`error` for one cycle. The other port's outputs stay 0.
  - Go to IDLE.
- **Requester rule**: a requester deasserts `read`/`write` on the edge where it samples its `done` high. Requests are sampled only in IDLE.
- `rf_done` seen in any state other than WAIT is ignored.
- A request from the non-granted port is held off until the current transaction completes. No request is ever dropped.
- **Reset**: `rst` high forces IDLE, `last_grant`=1 (so port 0 wins the first tie), and every output to 0. An in-flight transaction is abandoned with no `done`.

## Timing
- Reset values: all `m*_rdata`, `m*_done`, `m*_error`, `rf_*` outputs, `busy` and `grant` are 0.
- Request first high in IDLE at cycle 0 → `rf_read`/`rf_write` pulse in cycle 1.
- With a register file that asserts `rf_done` in the cycle after the pulse: `rf_done` in cycle 2, port `done` in cycle 3.
- General latency: the port's `done` appears 3 + (extra `rf_done` delay) cycles after the request is first seen.
- Illegal request: `done` with `error`=1 in cycle 2.
- Back-to-back: an already-pending request on the other port is granted in the IDLE cycle right after RESP. Its pulse follows one cycle later.
- Minimum spacing between `rf` pulses: 4 cycles.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - WAIT runs an 8-bit counter cleared on entry.
  - If `rf_done` is not seen within `TIMEOUT` WAIT cycles, go to RESP with `error`=1 and `rdata`=0.
  - A later stray `rf_done` is ignored.
- `ARB_TIMEOUT_EN` not defined: no counter; WAIT holds indefinitely until `rf_done`.

## Test plan
- **Write then read**: m0 writes addr 0x10, data 0x0002, then reads 0x10 → one `rf_write` pulse with 0x10/0x0002. Then `m0_done` with `error`=0. The read returns `m0_rdata`=0x0002; `m1_done` never pulses.
- **Simultaneous reads, first after reset**: m0 and m1 both raise `read` in the same cycle → m0 is served first, then m1. `grant` goes 0 then 1; `rf` pulses are 4 cycles apart with a 1-cycle regfile.
- **Sustained contention**: both ports issue 4 reads continuously → grants strictly alternate 0,1,0,1,… and each port gets exactly 4 `done` pulses.
- **Illegal request**: m1 raises `read`=`write`=1 at addr 0x12 → no `rf_read`/`rf_write` pulse; `m1_done`=1 with `m1_error`=1 and `m1_rdata`=0 two cycles after the request.
- **Regfile error**: m0 reads an unmapped addr 0xFF and the regfile returns `rf_error`=1 → `m0_error`=1, `m0_rdata`=0.
- **Timeout and reset** (`ARB_TIMEOUT_EN`, `TIMEOUT`=16):
  - Stall `rf_done` → `m0_done`/`m0_error`=1 after 16 WAIT cycles.
  - Separately, assert `rst` during WAIT → all outputs 0 next cycle, state IDLE, no `done` issued.
